// File: rtl/sobel_pkg.sv
// Shared definitions for the CONV_SOBEL stream controller: FSM states, output tag
// payload and frame-geometry helpers used by the controller, the core build and benches.
package sobel_pkg;

  localparam int unsigned SOBEL_PIPE_LATENCY = 48;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    CLEAR = 2'd3
  } sobel_state_e;

  // Output-side qualifiers presented alongside the core's out_frame
  typedef struct packed {
    logic tvalid;
    logic tlast;
    logic tuser;
  } sobel_mtag_t;

  function automatic int unsigned sobel_beats_per_row(input int unsigned dim,
                                                      input int unsigned ppb);
    return dim / ppb;
  endfunction

  function automatic int unsigned sobel_total_beats(input int unsigned dim,
                                                    input int unsigned ppb);
    return dim * (dim / ppb);
  endfunction

endpackage

// File: rtl/sobel_vld_pipe.sv
// Valid-bit delay line that tracks which core pipeline slots hold real pixels;
// advances only when the core advances so it stays aligned with out_frame.
module sobel_vld_pipe #(
  parameter int unsigned DEPTH = 48
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_shift,
  input  logic i_din,
  output logic o_tail
);

  logic [DEPTH-1:0] r_sr;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_sr <= '0;
    end else if (i_shift) begin
      r_sr <= (r_sr << 1) | DEPTH'(i_din);
    end
  end

  assign o_tail = r_sr[DEPTH-1];

endmodule

// File: rtl/sobel_stream_ctrl.sv
// AXI-Stream sequencer for the CONV_SOBEL core: gates core advance, flushes the
// core pipeline after the last input beat and resets the core between frames.
module sobel_stream_ctrl
  import sobel_pkg::*;
#(
  parameter int unsigned PIXELS_PER_BEAT = 16,
  parameter int unsigned IMAGE_DIM       = 512,
  parameter int unsigned PIPE_LATENCY    = SOBEL_PIPE_LATENCY,
  parameter int unsigned DATA_WIDTH      = 8 * PIXELS_PER_BEAT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tuser,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  m_tuser,
  output logic                  core_stall,
  output logic                  core_aresetn,
  output logic [DATA_WIDTH-1:0] core_inp,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  sof_err
);

  localparam int unsigned BEATS_PER_ROW = sobel_beats_per_row(IMAGE_DIM, PIXELS_PER_BEAT);
  localparam int unsigned TOTAL         = sobel_total_beats(IMAGE_DIM, PIXELS_PER_BEAT);
  localparam int unsigned CW            = $clog2(TOTAL + 1);
  localparam int unsigned FW            = $clog2(PIPE_LATENCY + 1);

  sobel_state_e  r_state;
  logic [CW-1:0] r_in_cnt;
  logic [CW-1:0] r_out_cnt;
  logic [FW-1:0] r_flush_cnt;
  sobel_mtag_t   r_mtag;
  logic          r_busy;
  logic          r_frame_done;
  logic          r_sof_err;

  logic          w_run;
  logic          w_flush;
  logic          w_clr;
  logic          w_blocked;
  logic          w_adv;
  logic          w_accept;
  logic          w_hs;
  logic          w_in_last;
  logic          w_out_last;
  logic          w_tail;
  logic [CW-1:0] w_out_cnt_nxt;
  sobel_mtag_t   w_mtag_nxt;

  assign w_run      = (r_state == RUN);
  assign w_flush    = (r_state == FLUSH);
  assign w_clr      = (r_state == CLEAR);
  assign w_blocked  = r_mtag.tvalid & ~m_tready;
  assign w_adv      = ~w_blocked & ((w_run & s_tvalid) |
                                    (w_flush & (r_flush_cnt < FW'(PIPE_LATENCY))));
  assign w_accept   = w_run & s_tvalid & ~w_blocked;
  assign w_hs       = r_mtag.tvalid & m_tready;
  assign w_in_last  = (r_in_cnt == CW'(TOTAL - 1));
  assign w_out_last = (r_out_cnt == CW'(TOTAL - 1));

  // Flush beats shift a 0 so drained slots never raise m_tvalid
  sobel_vld_pipe #(
    .DEPTH (PIPE_LATENCY)
  ) u_vld_pipe (
    .i_clk   (clk),
    .i_reset (reset),
    .i_clr   (w_clr),
    .i_shift (w_adv),
    .i_din   (w_run),
    .o_tail  (w_tail)
  );

  // Next presented beat: a core advance loads the new tail even while the current beat hands off
  always_comb begin
    w_mtag_nxt    = '0;
    w_out_cnt_nxt = r_out_cnt + CW'(w_hs);
    if (w_clr) begin
      w_out_cnt_nxt = '0;
    end else if (w_adv) begin
      w_mtag_nxt.tvalid = w_tail;
    end else if (!m_tready) begin
      w_mtag_nxt.tvalid = r_mtag.tvalid;
    end
    w_mtag_nxt.tuser = w_mtag_nxt.tvalid & (w_out_cnt_nxt == '0);
    w_mtag_nxt.tlast = w_mtag_nxt.tvalid &
                       ((w_out_cnt_nxt % CW'(BEATS_PER_ROW)) == CW'(BEATS_PER_ROW - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_in_cnt     <= '0;
      r_out_cnt    <= '0;
      r_flush_cnt  <= '0;
      r_mtag       <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_sof_err    <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_sof_err    <= w_accept & s_tuser & (r_in_cnt != '0);
      r_mtag       <= w_mtag_nxt;
      r_out_cnt    <= w_out_cnt_nxt;

      if (w_clr) begin
        r_in_cnt    <= '0;
        r_flush_cnt <= '0;
      end else begin
        if (w_accept) begin
          r_in_cnt <= r_in_cnt + CW'(1);
        end
        if (w_adv && w_flush) begin
          r_flush_cnt <= r_flush_cnt + FW'(1);
        end
      end

      unique case (r_state)
        IDLE: begin
          if (en) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
          end
        end
        RUN: begin
          if (w_accept && w_in_last) begin
            r_state <= FLUSH;
          end
        end
        FLUSH: begin
          if (w_hs && w_out_last) begin
            r_state      <= CLEAR;
            r_frame_done <= 1'b1;
          end
        end
        CLEAR: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign s_tready     = w_run & ~w_blocked;
  assign core_stall   = ~w_adv;
  assign core_aresetn = ~reset & ~w_clr;
  assign core_inp     = w_run ? s_tdata : '0;
  assign m_tvalid     = r_mtag.tvalid;
  assign m_tlast      = r_mtag.tlast;
  assign m_tuser      = r_mtag.tuser;
  assign busy         = r_busy;
  assign frame_done   = r_frame_done;
  assign sof_err      = r_sof_err;

endmodule
